// File: rtl/mux_gate_pkg.sv
// Shared opcode and FSM state definitions for the mux-gate arbiter.
package mux_gate_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_XNOR = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mux_gate_unit.sv
// Combinational WIDTH-bit logic unit; every gate and the opcode select are 2:1 muxes.
module mux_gate_unit #(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic g_xor, g_xnor, g_and, g_or;
            g_xor  = a[i] ? ~b[i] : b[i];
            g_xnor = a[i] ? b[i]  : ~b[i];
            g_and  = b[i] ? a[i]  : 1'b0;
            g_or   = b[i] ? 1'b1  : a[i];
            y[i]   = op[1] ? (op[0] ? g_or : g_and) : (op[0] ? g_xnor : g_xor);
        end
    end

endmodule

// File: rtl/mux_gate_arbiter.sv
// Arbitrates NREQ clients onto one shared mux_gate_unit with a registered valid/ack response.
// Define MUX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state  | meaning
// S_IDLE | waiting for any req; picks winner, latches op/A/B, raises gnt
// S_EXEC | shared unit evaluates latched operands; result registered
// S_RESP | rsp_valid high, outputs held until rsp_ack
module mux_gate_arbiter
    import mux_gate_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_data,
    input  logic                    rsp_ack
);

    localparam int IDW = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0]   unit_y;
    logic [IDW-1:0]     pick;
`ifndef MUX_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
`endif

    mux_gate_unit #(.WIDTH(WIDTH)) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (unit_y)
    );

    // First set request scanning upward from the search origin, wrapping at NREQ.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
`ifdef MUX_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % NREQ;
`endif
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        gnt_d       = gnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != '0) begin
                    win_d        = pick;
                    op_d         = req_op[2*int'(pick) +: 2];
                    a_d          = req_a[WIDTH*int'(pick) +: WIDTH];
                    b_d          = req_b[WIDTH*int'(pick) +: WIDTH];
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = unit_y;
                rsp_id_d    = win_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ack) begin
                    gnt_d       = '0;
                    rsp_valid_d = 1'b0;
`ifndef MUX_ARB_FIXED_PRIO_EN
                    ptr_d       = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// Scoreboard bench for mux_gate_arbiter: stimulus queues expected {id,data}, monitor checks on each new rsp_valid.
module tb_mux_gate_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  req_op = 8'h00;
    logic [15:0] req_a = 16'h0000;
    logic [15:0] req_b = 16'h0000;
    logic [3:0]  gnt;
    logic        busy;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_ack = 1'b0;

    int total = 0;
    int bad = 0;
    logic [5:0] exp_q[$];
    logic ack_en = 1'b1;
    logic auto_drop = 1'b1;
    logic prev_v = 1'b0;

    mux_gate_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack)
    );

    always #5 clk = ~clk;

    // Hand-computed results for a=1100, b=1010.
    function automatic logic [3:0] res(input logic [1:0] op);
        case (op)
            2'b00:   res = 4'b0110;
            2'b01:   res = 4'b1001;
            2'b10:   res = 4'b1000;
            default: res = 4'b1110;
        endcase
    endfunction

    always @(negedge clk) rsp_ack = ack_en && rsp_valid;

    always @(negedge clk) begin
        if (auto_drop) req = req & ~gnt;
    end

    always @(negedge clk) begin
        if (rsp_valid && !prev_v) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected actual id=%0d data=%b required=no response", rsp_id, rsp_data);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data} !== e) begin
                    bad++;
                    $display("FAIL rsp actual id=%0d data=%b required id=%0d data=%b",
                             rsp_id, rsp_data, e[5:4], e[3:0]);
                end
            end
        end
        prev_v = rsp_valid;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [1:0] o3, input logic [1:0] o2, input logic [1:0] o1, input logic [1:0] o0);
        req_op = {o3, o2, o1, o0};
        req_a  = {4{4'b1100}};
        req_b  = {4{4'b1010}};
    endtask

    task automatic push(input logic [1:0] id, input logic [1:0] op);
        exp_q.push_back({id, res(op)});
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 100 && !(exp_q.size() == 0 && !busy && !rsp_valid && req == 4'b0000)) begin
            step();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL %s_timeout actual=pending %0d required=0", name, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with all requests held.
        auto_drop = 1'b0;
        set_ops(2'b00, 2'b00, 2'b00, 2'b00);
        req = 4'b1111;
        step();
        step();
        step();
        chk("reset_outputs", {gnt, busy, rsp_valid, rsp_id, rsp_data}, 32'h0);
        push(2'd0, 2'b00);
        rst_n = 1'b1;
        step();
        chk("reset_release_gnt", gnt, 4'b0001);
        req = 4'b0000;
        wait_idle("reset");

        // Single request; operand change after capture must not matter.
        do_reset();
        auto_drop = 1'b1;
        set_ops(2'b00, 2'b00, 2'b00, 2'b00);
        push(2'd0, 2'b00);
        req = 4'b0001;
        step();
        chk("single_gnt_busy", {gnt, busy, rsp_valid}, {4'b0001, 1'b1, 1'b0});
        req_a[3:0] = 4'b0011;
        wait_idle("single");

        // Fairness: two full rounds from pointer 0.
        do_reset();
        set_ops(2'b00, 2'b11, 2'b10, 2'b01);
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 2'b01);
            push(2'd1, 2'b10);
            push(2'd2, 2'b11);
            push(2'd3, 2'b00);
            req = 4'b1111;
            wait_idle("fair");
        end

        // Backpressure: hold response 5 cycles with requester 1 pending.
        do_reset();
        set_ops(2'b00, 2'b00, 2'b11, 2'b10);
        ack_en = 1'b0;
        push(2'd0, 2'b10);
        push(2'd1, 2'b11);
        req = 4'b0011;
        begin
            int n;
            n = 0;
            while (n < 20 && !rsp_valid) begin
                step();
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("backpressure_hold", {rsp_valid, rsp_id, rsp_data, gnt, req},
                {1'b1, 2'd0, 4'b1000, 4'b0001, 4'b0010});
            step();
        end
        ack_en = 1'b1;
        wait_idle("backpressure");

        // Reset during EXEC with request 2 held.
        do_reset();
        auto_drop = 1'b0;
        set_ops(2'b00, 2'b11, 2'b00, 2'b00);
        req = 4'b0100;
        step();
        chk("midrst_exec_gnt", {gnt, busy, rsp_valid}, {4'b0100, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {gnt, busy, rsp_valid, rsp_id, rsp_data}, 32'h0);
        step();
        step();
        push(2'd2, 2'b11);
        rst_n = 1'b1;
        step();
        chk("midrst_regrant", gnt, 4'b0100);
        req = 4'b0000;
        wait_idle("midrst");

        // Held req=1010: fixed priority always picks 1, round-robin alternates 1,3,1.
        do_reset();
        set_ops(2'b10, 2'b00, 2'b01, 2'b00);
`ifdef MUX_ARB_FIXED_PRIO_EN
        push(2'd1, 2'b01);
        push(2'd1, 2'b01);
        push(2'd1, 2'b01);
`else
        push(2'd1, 2'b01);
        push(2'd3, 2'b10);
        push(2'd1, 2'b01);
`endif
        req = 4'b1010;
        begin
            int n;
            n = 0;
            while (n < 60 && exp_q.size() != 0) begin
                step();
                n++;
            end
        end
        req = 4'b0000;
        wait_idle("held_1010");
        auto_drop = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
